// File: rtl/boot_request_pkg.sv
// rtl/boot_request_pkg.sv - shared command codes, register map and FSM states for boot_request
package boot_request_pkg;

  localparam logic [7:0] CMD_UNLOCK = 8'h5A;
  localparam logic [7:0] CMD_BOOT   = 8'hB0;

  localparam logic [1:0] REG_ADDR_LO  = 2'd0;
  localparam logic [1:0] REG_ADDR_MID = 2'd1;
  localparam logic [1:0] REG_ADDR_HI  = 2'd2;
  localparam logic [1:0] REG_CMD      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

endpackage

// File: rtl/boot_request_button_debounce.sv
// rtl/boot_request_button_debounce.sv - boot button synchroniser, debounce and long-press one-shot
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
  parameter logic [19:0] HOLD_CYCLES     = 20'd1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic boot,
  output logic long_press
);

  logic [1:0]  sync;
  logic        filtered;
  logic [15:0] deb_cnt;
  logic [19:0] hold_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync       <= 2'b00;
      filtered   <= 1'b0;
      deb_cnt    <= 16'd0;
      hold_cnt   <= 20'd0;
      long_press <= 1'b0;
    end else begin
      // Button is active-low; the synchroniser carries the "pressed" sense.
      sync <= {sync[0], ~boot};

      if (sync[1] != filtered) begin
        if (deb_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          filtered <= sync[1];
          deb_cnt  <= 16'd0;
        end else begin
          deb_cnt <= deb_cnt + 16'd1;
        end
      end else begin
        deb_cnt <= 16'd0;
      end

      // Saturating counter makes the pulse a one-shot until release.
      long_press <= 1'b0;
      if (!filtered) begin
        hold_cnt <= 20'd0;
      end else if (hold_cnt != HOLD_CYCLES) begin
        hold_cnt   <= hold_cnt + 20'd1;
        long_press <= (hold_cnt == HOLD_CYCLES - 20'd1);
      end
    end
  end

endmodule

// File: rtl/boot_request.sv
// rtl/boot_request.sv - arbitrates CPU and long-press reboot requests into a one-cycle strobe plus flash address
module boot_request
  import boot_request_pkg::*;
#(
  parameter logic [23:0] DEFAULT_ADDR    = 24'h000000,
  parameter logic [19:0] HOLD_CYCLES     = 20'd1000000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
  parameter logic [7:0]  COOLDOWN_CYCLES = 8'd32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        boot,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [7:0]  data,
  output logic        reboot,
  output logic [23:0] spi_addr,
  output logic        busy
);

  state_t      state;
  logic [23:0] addr_reg;
  logic [7:0]  cool_cnt;
  logic        btn_req;
  logic        cmd_wr;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_button (
    .clock     (clock),
    .reset     (reset),
    .boot      (boot),
    .long_press(btn_req)
  );

  assign cmd_wr = wr && (addr == REG_CMD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_reg <= DEFAULT_ADDR;
      spi_addr <= DEFAULT_ADDR;
      reboot   <= 1'b0;
      busy     <= 1'b0;
      cool_cnt <= 8'd0;
    end else begin
      reboot <= 1'b0;

      if (wr && state != ST_FIRE) begin
        case (addr)
          REG_ADDR_LO:  addr_reg[7:0]   <= data;
          REG_ADDR_MID: addr_reg[15:8]  <= data;
          REG_ADDR_HI:  addr_reg[23:16] <= data;
          default:      ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (btn_req) begin
            state    <= ST_FIRE;
            spi_addr <= DEFAULT_ADDR;
            reboot   <= 1'b1;
            busy     <= 1'b1;
          end else if (cmd_wr && data == CMD_UNLOCK) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          // A long press outranks a simultaneous CPU boot command.
          if (btn_req) begin
            state    <= ST_FIRE;
            spi_addr <= DEFAULT_ADDR;
            reboot   <= 1'b1;
          end else if (cmd_wr) begin
            if (data == CMD_BOOT) begin
              state    <= ST_FIRE;
              spi_addr <= addr_reg;
              reboot   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_FIRE: begin
          state    <= ST_COOLDOWN;
          cool_cnt <= 8'd0;
        end
        ST_COOLDOWN: begin
          if (cool_cnt == COOLDOWN_CYCLES - 8'd1) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cool_cnt <= 8'd0;
          end else begin
            cool_cnt <= cool_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
